// File: rtl/sum_tx_pkg.sv
// Shared types and constants for the adder's serial transmit path.
package sum_tx_pkg;

    localparam int DATA_W = 8;
    localparam int SUM_W  = DATA_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        CARRY = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module sum_tx_baud_gen
    import sum_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: restart on clear or at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sum_uart_tx.sv
// Adds two bytes and ships the 9-bit result as start, 8 data bits LSB first, carry, stop bit(s).
module sum_uart_tx
    import sum_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic [SUM_W-1:0]  sum_out
);

    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t          state_q, state_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               tx_q, tx_d;
    logic               ready_q, ready_d;
    logic               tick_s;
    logic               clear_s;
    logic               accept_s;

    assign accept_s = in_valid && ready_q;
    // The counter is held at zero while idle so START always gets a full bit period.
    assign clear_s  = (state_d != state_q) || (state_q == IDLE);

    sum_tx_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear_s),
        .tick (tick_s)
    );

    // Frame sequencing, operand capture and the next serial level.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        sum_d     = sum_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sum_d   = {1'b0, a_in} + {1'b0, b_in};
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = CARRY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            CARRY: begin
                if (tick_s) begin
                    state_d = STOP;
                end else begin
                    state_d = CARRY;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            bit_idx_d = 3'd0;
        end else begin
            bit_idx_d = bit_idx_d;
        end

        // tx is decoded from the next state so the line changes on the same edge as the state.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = sum_d[bit_idx_d];
            CARRY:   tx_d = sum_d[SUM_W-1];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= 3'd0;
            sum_q     <= {SUM_W{1'b0}};
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            sum_q     <= sum_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
        end
    end

    assign tx       = tx_q;
    assign in_ready = ready_q;
    assign busy     = ~ready_q;
    assign sum_out  = sum_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: two instances (4 clk/bit 1 stop, 2 clk/bit 2 stops) against a frame-position model.
module tb_sum_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a_in;
    logic [7:0] b_in;

    logic       in_ready_a, tx_a, busy_a;
    logic [8:0] sum_a;
    logic       in_ready_b, tx_b, busy_b;
    logic [8:0] sum_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state per instance: position in frame (-1 = idle) and latched sum.
    int         mpos [2];
    logic [8:0] msum [2];
    bit         mtx  [2];
    bit         mrdy [2];

    always #5 clk = ~clk;

    sum_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a), .sum_out(sum_a)
    );

    sum_uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b), .sum_out(sum_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Serial bit number i of a frame: 0 start, 1..8 data LSB first, 9 carry, then stop bits.
    function automatic bit frame_bit(input logic [8:0] s, input int i);
        if (i == 0)      return 1'b0;
        else if (i <= 8) return s[i-1];
        else if (i == 9) return s[8];
        else             return 1'b1;
    endfunction

    task automatic model_step(input int k, input int c, input int s);
        if (rst) begin
            mpos[k] = -1;
            msum[k] = 9'h000;
        end else if (mpos[k] < 0) begin
            if (in_valid && mrdy[k]) begin
                msum[k] = 9'(a_in) + 9'(b_in);
                mpos[k] = 0;
            end
        end else begin
            mpos[k] = mpos[k] + 1;
            if (mpos[k] >= (10 + s) * c) mpos[k] = -1;
        end
        if (mpos[k] < 0) begin
            mtx[k]  = 1'b1;
            mrdy[k] = 1'b1;
        end else begin
            mtx[k]  = frame_bit(msum[k], mpos[k] / c);
            mrdy[k] = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, 4, 1);
        model_step(1, 2, 2);
        @(negedge clk);
        chk("tx_a",    32'(tx_a),       32'(mtx[0]));
        chk("ready_a", 32'(in_ready_a), 32'(mrdy[0]));
        chk("busy_a",  32'(busy_a),     32'(!mrdy[0]));
        chk("sum_a",   32'(sum_a),      32'(msum[0]));
        chk("tx_b",    32'(tx_b),       32'(mtx[1]));
        chk("ready_b", 32'(in_ready_b), 32'(mrdy[1]));
        chk("busy_b",  32'(busy_b),     32'(!mrdy[1]));
        chk("sum_b",   32'(sum_b),      32'(msum[1]));
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 500) begin
            cycle();
            n++;
        end
        chk("idle_timeout", 32'(n < 500), 32'd1);
        cycle();
    endtask

    task automatic frame_len_a(input string tag, input int want);
        int n;
        n = 0;
        while (busy_a === 1'b1 && n < 200) begin
            n++;
            cycle();
        end
        chk(tag, 32'(n), 32'(want));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mpos[k] = -1;
            msum[k] = 9'h000;
            mtx[k]  = 1'b1;
            mrdy[k] = 1'b1;
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        a_in     = 8'h00;
        b_in     = 8'h00;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_sum",   32'(sum_a),      32'h000);
        chk("rst_tx",    32'(tx_a),       32'd1);
        chk("rst_ready", 32'(in_ready_a), 32'd1);

        // Directed frames from the worked examples.
        send(8'h0F, 8'h01);
        chk("sum_0f_01", 32'(sum_a), 32'h010);
        frame_len_a("len_0f_01", 44);
        wait_idle();
        send(8'hFF, 8'h01);
        chk("sum_ff_01", 32'(sum_a), 32'h100);
        wait_idle();
        send(8'hFF, 8'hFF);
        chk("sum_ff_ff", 32'(sum_a), 32'h1FE);
        wait_idle();

        // Two stop bits at two clocks per bit: 24-cycle frame.
        send(8'h80, 8'h00);
        begin
            int n;
            n = 0;
            while (busy_b === 1'b1 && n < 200) begin
                n++;
                cycle();
            end
            chk("len_b_stop2", 32'(n), 32'd24);
        end
        wait_idle();

        // in_valid held high with operands changing every cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset in the middle of data bit 3 of instance A, then a clean frame.
        send(8'h55, 8'h22);
        for (int i = 0; i < 17; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_tx",    32'(tx_a),       32'd1);
        chk("midrst_ready", 32'(in_ready_a), 32'd1);
        chk("midrst_sum",   32'(sum_a),      32'h000);
        send(8'h3C, 8'hC3);
        chk("sum_3c_c3", 32'(sum_a), 32'h0FF);
        frame_len_a("len_after_rst", 44);
        wait_idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
